// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: multi-cycle mult/multu/div/divu with Busy, single-cycle mthi/mtlo.
// Optional accumulate ops (madd/maddu/msub/msubu) are built when MDU_MADD_EN is defined.
module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t               r_state, w_state_nx;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
  logic [WIDTH-1:0]     r_hi, r_lo, w_hi_nx, w_lo_nx;
  logic [2*WIDTH-1:0]   r_pend, w_pend_nx;
  logic                 r_pend_wr, w_pend_wr_nx;

  logic [2*WIDTH-1:0]   w_sprod, w_uprod;
  logic                 w_sdiv, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_da, w_dsr, w_q, w_r, w_quo, w_rem;

  // Lower 2W bits of a sign-extended product equal the signed product
  assign w_sprod = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign w_uprod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Signed divide via magnitudes; the -2^(W-1)/-1 case falls out as quotient 0x80..0, remainder 0
  assign w_sdiv  = (Op == OP_DIV);
  assign w_a_neg = w_sdiv & A[WIDTH-1];
  assign w_b_neg = w_sdiv & B[WIDTH-1];
  assign w_da    = w_a_neg ? (~A + ONE) : A;
  assign w_dsr   = (B == {WIDTH{1'b0}}) ? ONE : (w_b_neg ? (~B + ONE) : B);
  assign w_q     = w_da / w_dsr;
  assign w_r     = w_da % w_dsr;
  assign w_quo   = (w_a_neg ^ w_b_neg) ? (~w_q + ONE) : w_q;
  assign w_rem   = w_a_neg ? (~w_r + ONE) : w_r;

  assign Busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Next-state, counter and HI/LO update logic
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    w_pend_nx    = r_pend;
    w_pend_wr_nx = r_pend_wr;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            OP_MTHI: w_hi_nx = A;
            OP_MTLO: w_lo_nx = A;
            OP_MULT, OP_MULTU: begin
              w_pend_nx    = (Op == OP_MULT) ? w_sprod : w_uprod;
              w_pend_wr_nx = 1'b1;
              w_cnt_nx     = CNT_W'(MULT_CYCLES);
              w_state_nx   = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              w_pend_nx    = {w_rem, w_quo};
              w_pend_wr_nx = (B != {WIDTH{1'b0}});
              w_cnt_nx     = CNT_W'(DIV_CYCLES);
              w_state_nx   = S_RUN;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              if (Op == OP_MADD)       w_pend_nx = {r_hi, r_lo} + w_sprod;
              else if (Op == OP_MADDU) w_pend_nx = {r_hi, r_lo} + w_uprod;
              else if (Op == OP_MSUB)  w_pend_nx = {r_hi, r_lo} - w_sprod;
              else                     w_pend_nx = {r_hi, r_lo} - w_uprod;
              w_pend_wr_nx = 1'b1;
              w_cnt_nx     = CNT_W'(MULT_CYCLES);
              w_state_nx   = S_RUN;
            end
`endif
            default: ;
          endcase
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_ONE) begin
          if (r_pend_wr) begin
            w_hi_nx = r_pend[2*WIDTH-1:WIDTH];
            w_lo_nx = r_pend[WIDTH-1:0];
          end else begin
            w_hi_nx = r_hi;
          end
          w_cnt_nx   = {CNT_W{1'b0}};
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State and architectural register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_pend    <= {(2*WIDTH){1'b0}};
      r_pend_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
      r_pend    <= w_pend_nx;
      r_pend_wr <= w_pend_wr_nx;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected Busy length and HI/LO; a negedge monitor checks on Busy fall.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  Op;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_op(input int len, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.len = len; e.hi = hi; e.lo = lo;
    q.push_back(e);
  endtask

  // Drive a one-cycle Start from the current (off-edge) time
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Op = 4'd0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (Busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (Busy) chk("busy_timeout", 64'(Busy), 64'd0);
  endtask

  // Monitor: measure each Busy pulse, check HI/LO hold, then compare against the scoreboard
  logic        prev_busy = 1'b0;
  int          bcnt = 0;
  logic [31:0] hold_hi, hold_lo;
  logic        hold_bad;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_busy = 1'b0;
      bcnt      = 0;
    end else begin
      if (Busy) begin
        if (!prev_busy) begin
          hold_hi = HI; hold_lo = LO; hold_bad = 1'b0; bcnt = 0;
        end
        bcnt++;
        if (HI !== hold_hi || LO !== hold_lo) hold_bad = 1'b1;
      end else if (prev_busy) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("busy_len", 64'(bcnt), 64'(e.len));
          chk("hilo_hold", 64'(hold_bad), 64'd0);
          chk("result_hi", 64'(HI), 64'(e.hi));
          chk("result_lo", 64'(LO), 64'(e.lo));
        end
      end
      prev_busy = Busy;
    end
  end

  initial begin
    int k;
    reset = 1'b1; Start = 1'b0; Op = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_hi", 64'(HI), 64'd0);
    chk("reset_lo", 64'(LO), 64'd0);

    // Abort a div with a 2-cycle reset; its result must never land
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(HI), 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_late_hi", 64'(HI), 64'd0);
    chk("abort_late_lo", 64'(LO), 64'd0);

    expect_op(5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle();
    expect_op(5, 32'h00000002, 32'hFFFFFFFA);
    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle();

    expect_op(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    expect_op(10, 32'h00000001, 32'h00000003);
    issue(4'd4, 32'd7, 32'd2);
    wait_idle();

    issue(4'd5, 32'h12345678, 32'd0);
    chk("mthi_busy", 64'(Busy), 64'd0);
    chk("mthi_hi", 64'(HI), 64'h12345678);
    issue(4'd6, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_lo", 64'(LO), 64'h9ABCDEF0);
    chk("mtlo_hi_kept", 64'(HI), 64'h12345678);
    expect_op(10, 32'h12345678, 32'h9ABCDEF0);
    issue(4'd3, 32'h00001234, 32'd0);
    wait_idle();
    expect_op(10, 32'h00000000, 32'h80000000);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();

    // mtlo while Busy is dropped; the next Start right after Busy falls is taken
    expect_op(5, 32'h00000000, 32'h00000006);
    issue(4'd1, 32'd2, 32'd3);
    issue(4'd6, 32'h55, 32'd0);
    wait_idle();
    issue(4'd6, 32'h77, 32'd0);
    chk("turnaround_lo", 64'(LO), 64'h77);
    chk("turnaround_busy", 64'(Busy), 64'd0);

`ifdef MDU_MADD_EN
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    expect_op(5, 32'h00000001, 32'h00000000);
    issue(4'd8, 32'd1, 32'd1);
    wait_idle();
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd0, 32'd0);
    expect_op(5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(4'd9, 32'd1, 32'd1);
    wait_idle();
`else
    issue(4'd7, 32'd1, 32'd1);
    chk("noop7_busy", 64'(Busy), 64'd0);
    issue(4'd9, 32'd1, 32'd1);
    chk("noop9_busy", 64'(Busy), 64'd0);
    chk("noop_hi", 64'(HI), 64'h00000000);
    chk("noop_lo", 64'(LO), 64'h77);
`endif

    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Parametrised multiply/divide unit for the P5/P6 pipelined MIPS core; sits in EX beside the combinational ALU.
- Owns the HI/LO architectural registers.
- Executes mult/multu/div/divu as multi-cycle operations with a Busy handshake.
- mthi/mtlo complete in a single cycle; mfhi/mflo read the HI/LO outputs directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, Busy duration for multiply-class ops (≥1).
- DIV_CYCLES, 10, Busy duration for divide ops (≥1).
- CNT_W, 4, width of the internal cycle counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data).
- B  input  WIDTH  rt operand (divisor / multiplier).
- Op  input  4  operation select; sampled only when Start=1.
- Start  input  1  one-cycle request strobe from EX.
- Busy  output  1  multi-cycle operation in progress.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Clocking: single clock domain (clk); reset is synchronous and active-high. On a clk edge with reset=1: HI=0, LO=0, Busy=0, counter=0, pending result cleared. Reset overrides Start and aborts any in-flight operation; the aborted result is never written.
- Op encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo. With MDU_MADD_EN: 7 madd, 8 maddu, 9 msub, 10 msubu. All other codes are no-ops.
- Acceptance: Start is accepted only when Busy=0 at the same edge. Start while Busy=1 is ignored entirely; the pipeline is responsible for stalling on (Start|Busy).
- mthi/mtlo: at the accepting edge HI←A (mthi) or LO←A (mtlo). Busy stays 0.
- Multiply/divide at accepting edge E0:
  - A, B and Op are latched and the result is computed into a pending {hi, lo} register.
  - counter←N (N=MULT_CYCLES or DIV_CYCLES); Busy=1 from E0.
  - Each subsequent edge decrements the counter. At edge E_N (counter==1): {HI, LO}←pending, Busy←0, counter←0.
  - Busy is therefore high for exactly N cycles; new HI/LO are visible the cycle Busy falls.
  - HI/LO hold their old values throughout Busy.
  - A new Start is accepted at E_N+1 at the earliest (back-to-back with one idle-free turnaround).
- Arithmetic:
  - mult: signed 2W product; HI=upper W bits, LO=lower W bits.
  - multu: unsigned 2W product.
  - div: LO=quotient truncated toward zero; HI=remainder carrying the sign of the dividend.
  - div overflow case (−2^(W−1) / −1): LO=−2^(W−1), HI=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (B=0, div or divu): Busy still runs DIV_CYCLES; HI/LO are left unchanged at E_N.
- Busy depends only on registered state and never combinationally on Start.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Ops 7–10 are enabled, each using MULT_CYCLES latency.
  - The accumulator {HI, LO} is sampled at E0: madd={HI,LO}+signed(A*B), maddu uses the unsigned product, msub={HI,LO}−signed(A*B), msubu uses the unsigned product.
  - Results wrap modulo 2^(2W).
- Undefined: codes 7–10 are no-ops (no Busy, HI/LO unchanged), and no accumulate hardware is generated.

Test Plan:
- Reset: assert reset for 2 cycles during a div → Busy=0, HI=0, LO=0 at the next cycle; the aborted result never appears.
- mult A=0xFFFFFFFE (−2), B=3, Start one cycle → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. With multu on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=−7 (0xFFFFFFF9), B=2 → after 10 Busy cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu A=7, B=2 → LO=3, HI=1.
- div with B=0 after mthi 0x12345678 / mtlo 0x9ABCDEF0 → Busy runs 10 cycles, HI/LO unchanged. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Start with mtlo A=0x55 issued while Busy → ignored; LO takes the mult result, not 0x55. Start issued the cycle after Busy falls → accepted.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 → HI=1, LO=0. msub A=1, B=1 from {0,0} → HI=LO=0xFFFFFFFF.
